// File: rtl/counter_pkg.sv
// Shared definitions for the mod-MOD counter and the monitors that consume it.
package counter_pkg;

  // Defaults for the upstream counter shape.
  localparam int MOD_DEF   = 5;
  localparam int CNT_W_DEF = 3;

  // Monitor states. IDLE is the all-zero encoding so reset lands there.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  // Outcome of comparing a new count sample against the previous one.
  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_LEGAL   = 3'd1,
    CLS_WRAP    = 3'd2,
    CLS_RESTART = 3'd3,
    CLS_ERROR   = 3'd4
  } cls_t;

  // Successor of value in a mod-'mod' count. The wrap uses an explicit
  // compare against mod-1 rather than a modulo, so it behaves the same when
  // mod fills the whole counter width.
  function automatic logic [31:0] next_mod(input logic [31:0] value, input int mod);
    logic [31:0] last;
    last = 32'(mod - 1);
    if (value == last) begin
      return 32'd0;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/count_seq_monitor_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic at_max;

  // All-ones marks saturation; the counter never rolls over to zero.
  always_comb begin
    at_max = &q;
  end

  // Reset and clear both zero the count; increment is ignored once saturated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !at_max) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Sequence monitor for the mod-MOD down-edge counter: acquires on the first
// zero, checks each following sample against the expected successor, and
// reports wraps, errors and lock status through registered outputs.
module count_seq_monitor
  import counter_pkg::*;
#(
  parameter int MOD    = MOD_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = 16,
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [CNT_W-1:0]  count_in,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count,
  output logic              locked
);

  // Run length only needs to reach LOCK_N, after which it holds.
  localparam int RUN_W = $clog2(LOCK_N + 1);

  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_N);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MOD - 1);

  state_t           state;
  state_t           state_n;
  cls_t             cls;
  logic [CNT_W-1:0] prev_q;
  logic [CNT_W-1:0] prev_n;
  logic [CNT_W-1:0] exp_val;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_n;
  logic [RUN_W-1:0] run_inc;
  logic             wrap_evt;
  logic             err_evt;
  logic             locked_n;

  // Expected next sample and the saturated run length after one more legal step.
  always_comb begin
    exp_val = CNT_W'(next_mod(32'(prev_q), MOD));
    run_inc = (run_q >= LOCK_V) ? LOCK_V : run_q + RUN_W'(1);
  end

  // Classify the current sample; only meaningful while tracking and enabled.
  always_comb begin
    cls = CLS_NONE;
    if (state == TRACK && en) begin
      if (count_in == exp_val) begin
        cls = (prev_q == LAST_V) ? CLS_WRAP : CLS_LEGAL;
      end else if (count_in == '0) begin
        cls = CLS_RESTART;
      end else begin
        cls = CLS_ERROR;
      end
    end
  end

  // Next-state, tracking registers and event strobes.
  always_comb begin
    state_n  = state;
    prev_n   = prev_q;
    run_n    = run_q;
    wrap_evt = 1'b0;
    err_evt  = 1'b0;
    locked_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (en) begin
          state_n = ACQUIRE;
        end
      end

      ACQUIRE: begin
        if (!en) begin
          state_n = IDLE;
        end else if (count_in == '0) begin
          state_n = TRACK;
          prev_n  = '0;
          run_n   = '0;
        end
      end

      TRACK: begin
        if (!en) begin
          state_n = IDLE;
        end else begin
          unique case (cls)
            CLS_LEGAL: begin
              prev_n = count_in;
              run_n  = run_inc;
            end
            CLS_WRAP: begin
              prev_n   = count_in;
              run_n    = run_inc;
              wrap_evt = 1'b1;
            end
            CLS_RESTART: begin
              prev_n = '0;
              run_n  = '0;
            end
            CLS_ERROR: begin
              run_n   = '0;
              err_evt = 1'b1;
              state_n = ACQUIRE;
            end
            default: begin
              state_n = state;
            end
          endcase
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    locked_n = (state_n == TRACK) && (run_n >= LOCK_V);
  end

  // FSM state and tracking registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      prev_q <= '0;
      run_q  <= '0;
    end else begin
      state  <= state_n;
      prev_q <= prev_n;
      run_q  <= run_n;
    end
  end

  // Registered wrap strobe and lock flag; clear leaves both alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_pulse <= 1'b0;
      locked     <= 1'b0;
    end else begin
      wrap_pulse <= wrap_evt;
      locked     <= locked_n;
    end
  end

  // Sticky error flag; a same-cycle clear wins over a new error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_sticky <= 1'b0;
    end else if (clr) begin
      err_sticky <= 1'b0;
    end else if (err_evt) begin
      err_sticky <= 1'b1;
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap_evt),
    .clr (clr),
    .q   (wrap_count)
  );

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_evt),
    .clr (clr),
    .q   (err_count)
  );

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the monitor rules.
module tb_count_seq_monitor;

  localparam int MOD    = 5;
  localparam int CNT_W  = 3;
  localparam int WRAP_W = 4;
  localparam int ERR_W  = 3;
  localparam int LOCK_N = 5;
  localparam int WMAX   = (1 << WRAP_W) - 1;
  localparam int EMAX   = (1 << ERR_W) - 1;

  logic              clk;
  logic              rst;
  logic              en;
  logic              clr;
  logic [CNT_W-1:0]  count_in;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_count;
  logic              locked;

  int checks;
  int errors;

  // Model: mode 0 = off, 1 = waiting for a zero, 2 = following the count.
  int m_mode;
  int m_last;
  int m_run;
  int m_wraps;
  int m_errs;
  bit m_wrap;
  bit m_sticky;
  bit m_locked;

  int cnt;

  count_seq_monitor #(
    .MOD    (MOD),
    .CNT_W  (CNT_W),
    .WRAP_W (WRAP_W),
    .ERR_W  (ERR_W),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .count_in   (count_in),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .locked     (locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input bit r, input bit e, input bit c, input int v);
    bit wrap_inc;
    bit err_inc;
    wrap_inc = 0;
    err_inc  = 0;
    if (!r) begin
      m_mode = 0; m_last = 0; m_run = 0; m_wraps = 0; m_errs = 0;
      m_wrap = 0; m_sticky = 0; m_locked = 0;
      return;
    end
    if (!e) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (v == 0) begin
        m_mode = 2; m_last = 0; m_run = 0;
      end
    end else begin
      if (v == (m_last + 1) % MOD) begin
        if (m_last == MOD - 1) wrap_inc = 1;
        m_last = v;
        m_run  = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
      end else if (v == 0) begin
        m_last = 0; m_run = 0;
      end else begin
        err_inc = 1; m_run = 0; m_mode = 1;
      end
    end
    m_wrap   = wrap_inc;
    m_locked = (m_mode == 2) && (m_run >= LOCK_N);
    if (c) begin
      m_wraps = 0; m_errs = 0; m_sticky = 0;
    end else begin
      if (wrap_inc && m_wraps < WMAX) m_wraps++;
      if (err_inc && m_errs < EMAX) m_errs++;
      if (err_inc) m_sticky = 1;
    end
  endtask

  task automatic checkOutput();
    checkValue("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    checkValue("wrap_count", 32'(wrap_count), 32'(m_wraps));
    checkValue("err_sticky", 32'(err_sticky), 32'(m_sticky));
    checkValue("err_count",  32'(err_count),  32'(m_errs));
    checkValue("locked",     32'(locked),     32'(m_locked));
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit c, input int v);
    @(negedge clk);
    rst      = r;
    en       = e;
    clr      = c;
    count_in = CNT_W'(v);
    @(posedge clk);
    modelStep(r, e, c, v);
    #1;
    checkOutput();
  endtask

  // Advance the upstream counter n steps with enable on and no clear.
  task automatic runCount(input int n);
    for (int i = 0; i < n; i++) begin
      cnt = (cnt + 1) % MOD;
      applyStimulus(1, 1, 0, cnt);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; en = 1'b0; clr = 1'b0; count_in = '0;
    m_mode = 0; m_last = 0; m_run = 0; m_wraps = 0; m_errs = 0;
    m_wrap = 0; m_sticky = 0; m_locked = 0;
    cnt = 0;

    // 1. reset, acquire and free-run three periods
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkValue("rst_wrap_count", 32'(wrap_count), 32'd0);
    checkValue("rst_locked", 32'(locked), 32'd0);
    applyStimulus(1, 1, 0, 4);
    cnt = 0;
    applyStimulus(1, 1, 0, 0);
    runCount(4);
    checkValue("t1_not_locked_4", 32'(locked), 32'd0);
    runCount(1);
    checkValue("t1_locked_5", 32'(locked), 32'd1);
    checkValue("t1_wrap_pulse", 32'(wrap_pulse), 32'd1);
    runCount(10);
    checkValue("t1_wrap_count", 32'(wrap_count), 32'd3);
    checkValue("t1_err_count", 32'(err_count), 32'd0);

    // 2. skip from 2 to 4 while tracking
    runCount(2);
    applyStimulus(1, 1, 0, 4);
    checkValue("t2_err_sticky", 32'(err_sticky), 32'd1);
    checkValue("t2_err_count", 32'(err_count), 32'd1);
    checkValue("t2_locked", 32'(locked), 32'd0);
    cnt = 0;
    applyStimulus(1, 1, 0, 0);
    checkValue("t2_no_wrap", 32'(wrap_pulse), 32'd0);
    checkValue("t2_wrap_count", 32'(wrap_count), 32'd3);

    // 3. upstream restart 3 -> 0, then relock
    runCount(8);
    checkValue("t3_locked_before", 32'(locked), 32'd1);
    cnt = 0;
    applyStimulus(1, 1, 0, 0);
    checkValue("t3_restart_locked", 32'(locked), 32'd0);
    checkValue("t3_restart_err", 32'(err_count), 32'd1);
    checkValue("t3_restart_wrap", 32'(wrap_pulse), 32'd0);
    runCount(4);
    checkValue("t3_relock_4", 32'(locked), 32'd0);
    runCount(1);
    checkValue("t3_relock_5", 32'(locked), 32'd1);

    // 4. saturate both counters
    runCount(MOD * 20);
    checkValue("t4_wrap_sat", 32'(wrap_count), 32'(WMAX));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, 3);
      applyStimulus(1, 1, 0, 0);
    end
    checkValue("t4_err_sat", 32'(err_count), 32'(EMAX));
    cnt = 0;

    // 5. clear coinciding with a wrap and with an error
    runCount(4);
    cnt = 0;
    applyStimulus(1, 1, 1, 0);
    checkValue("t5_clr_wrap_pulse", 32'(wrap_pulse), 32'd1);
    checkValue("t5_clr_wrap_count", 32'(wrap_count), 32'd0);
    checkValue("t5_clr_err_count", 32'(err_count), 32'd0);
    applyStimulus(1, 1, 1, 2);
    checkValue("t5_clr_err_sticky", 32'(err_sticky), 32'd0);
    checkValue("t5_clr_err_count2", 32'(err_count), 32'd0);
    checkValue("t5_err_locked", 32'(locked), 32'd0);

    // 6. reset while locked, then disable mid-period
    applyStimulus(1, 1, 0, 3);
    cnt = 0;
    applyStimulus(1, 1, 0, 0);
    runCount(7);
    checkValue("t6_locked_before", 32'(locked), 32'd1);
    applyStimulus(0, 1, 0, 3);
    checkValue("t6_rst_locked", 32'(locked), 32'd0);
    checkValue("t6_rst_err_sticky", 32'(err_sticky), 32'd0);
    checkValue("t6_rst_wrap_count", 32'(wrap_count), 32'd0);
    applyStimulus(1, 1, 0, 4);
    cnt = 0;
    applyStimulus(1, 1, 0, 0);
    runCount(7);
    applyStimulus(1, 0, 0, 3);
    checkValue("t6_dis_locked", 32'(locked), 32'd0);
    checkValue("t6_dis_wrap_held", 32'(wrap_count), 32'd1);
    applyStimulus(1, 0, 0, 4);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 1);
    checkValue("t6_reacq_wrap", 32'(wrap_pulse), 32'd0);

    // Random traffic against the model
    cnt = 0;
    en  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int  r1;
      int  r2;
      int  v;
      bit  rr;
      bit  ee;
      bit  cc;
      r1 = int'($urandom_range(0, 99));
      r2 = int'($urandom_range(0, 99));
      rr = (r1 < 2) ? 1'b0 : 1'b1;
      ee = (int'($urandom_range(0, 99)) < 4) ? ~en : en;
      cc = (int'($urandom_range(0, 99)) < 3);
      if (r2 < 85) begin
        cnt = (cnt + 1) % MOD;
        v = cnt;
      end else if (r2 < 90) begin
        cnt = 0;
        v = 0;
      end else if (r2 < 95) begin
        v = cnt;
      end else begin
        v = int'($urandom_range(0, (1 << CNT_W) - 1));
        cnt = v % MOD;
      end
      applyStimulus(rr, ee, cc, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
